pc_display_driver: RTL and testbench
====================================

# pc_display_driver

Board-level consumer of the pipeline's exported program counter. It captures the 32-bit PC from the processor top level every cycle and scans it as 8 hex digits onto a multiplexed, common-anode seven-segment display. A debounced push-button freezes and unfreezes the captured value so an instruction address can be read while the pipeline keeps running.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit; must be ≥ 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed before a new button level is accepted; must be ≥ 2.

Ports:
- Clk  in  1  single system clock, shared with the pipeline.
- Rst  in  1  asynchronous, active-low reset.
- PC_in  in  32  program counter from the pipeline top level.
- Hold_in  in  1  raw, asynchronous, bouncing push-button; high = pressed.
- PC_shown  out  32  captured PC currently on the display.
- An_out  out  8  digit enables, active-low one-hot; bit i = digit i, and digit 0 is the least-significant nibble.
- Seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP_out  out  1  decimal point, active-low.

## Operation
- Capture: when not frozen, PC_shown <= PC_in every cycle. When frozen, PC_shown holds.
- Button path:
  - 2-flop synchronizer feeds a debouncer.
  - The debounce counter clears whenever the synchronized level equals the accepted level.
  - On a mismatch the counter increments. When it reaches DEBOUNCE_CYCLES-1 while the mismatch persists, the accepted level updates.
  - A rising edge of the accepted level toggles Frozen. Falling edges are ignored.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - At its terminal count the digit index idx advances 0→1→…→7→0.
- Output register updates every cycle:
  - An_out <= ~(1<<idx).
  - Seg_out <= hex7(PC_shown[4*idx+3:4*idx]).
  - DP_out <= ~(Frozen && idx==0).
- hex7 codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Reset values: PC_shown=0, An_out=8'hFF, Seg_out=7'h7F, DP_out=1, Frozen=0, idx=0, prescaler=0, debouncer state cleared with accepted level 0.

## Timing
- PC_in → PC_shown: 1 cycle.
- PC_shown → Seg_out for the active digit: 1 further cycle, so PC_in reaches the display in 2 cycles total.
- First rising edge after Rst deasserts: An_out=8'hFE, Seg_out=hex7(0)=7'h40.
- Digit period is SCAN_DIV cycles; a full frame is 8×SCAN_DIV cycles. Wrap from idx 7 to 0 adds no extra cycle.
- Hold_in press to Frozen: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 cycles. The PC sampled on the cycle Frozen rises is the value that is held.
- A bounce shorter than DEBOUNCE_CYCLES stable cycles produces no toggle.
- Freeze toggle and prescaler wrap in the same cycle are independent; both take effect.
- Rst asserted mid-scan or mid-debounce: every register returns to its reset value immediately, without waiting for a clock edge.

## Structure
- Package pc_display_pkg holds:
  - NUM_DIGITS=8.
  - SEG_BLANK=7'h7F.
  - the hex7 nibble-to-segment function / constant table.
- Sub-module hold_debouncer (synchronizer, counter, accepted level, rising-edge pulse out), parameterized by DEBOUNCE_CYCLES.
- The top of the block contains the capture register, prescaler, idx counter and output register.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=3.
- Rst=0 asserted between clock edges → outputs go to An_out=FF, Seg_out=7F, DP_out=1, PC_shown=0 without a clock edge.
- PC_in=0x00400004 held → An_out steps FE,FD,FB,…,7F every 4 cycles and returns to FE after 32 cycles. Seg_out=19 on digits 0 and 5, and 40 on all other digits.
- Hold_in high for 2 cycles then low → Frozen stays 0. Hold_in high for 10 cycles → Frozen=1 and PC_shown stays 0x00400004 while PC_in changes to 0x0040000C. DP_out=0 only while An_out=FE.
- Release, then press again for 10 cycles → Frozen=0, and PC_shown=0x0040000C one cycle later.
- PC_in=0xFEDCBA98 → Seg_out for digits 0..7 is 00,10,08,03,46,21,06,0E.
- Frozen=1 at idx=5, then Rst=0 → all reset values restored. After release, scanning restarts at An_out=FE with Frozen=0.

Source files
------------

// File: rtl/pc_display_pkg.sv
// Shared constants and the nibble-to-segment decode for the PC display driver.
package pc_display_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   typedef enum logic {
      DB_RELEASED = 1'b0,
      DB_PRESSED  = 1'b1
   } db_state_t;

   // Active-low {g,f,e,d,c,b,a} for a common-anode digit.
   function automatic logic [6:0] hex7(input logic [3:0] nibble);
      logic [6:0] seg;
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hold_debouncer.sv
// Synchronizes and debounces the hold push-button; emits a one-cycle pulse
// one cycle after a new pressed level is accepted.
//
// state       | meaning
// DB_RELEASED | accepted level 0, counting consecutive high samples
// DB_PRESSED  | accepted level 1, counting consecutive low samples
module hold_debouncer
   import pc_display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic hold_raw,
   output logic rise
);

   localparam int            CW     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   db_state_t     state;
   db_state_t     state_nxt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync_q <= '0;
         cnt    <= '0;
         state  <= DB_RELEASED;
         rise   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], hold_raw};
         cnt    <= cnt_nxt;
         state  <= state_nxt;
         rise   <= (state == DB_RELEASED) && (state_nxt == DB_PRESSED);
      end
   end

   // Any sample agreeing with the accepted level restarts the stability count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      if (sync_q[1] != (state == DB_PRESSED)) begin
         if (cnt == CNT_TC) begin
            state_nxt = sync_q[1] ? DB_PRESSED : DB_RELEASED;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_display_driver.sv
// Captures the pipeline PC and scans it as 8 hex digits onto a multiplexed
// common-anode seven-segment display; a push-button freezes the captured value.
module pc_display_driver
   import pc_display_pkg::*;
#(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [31:0]           PC_in,
   input  logic                  Hold_in,
   output logic [31:0]           PC_shown,
   output logic [NUM_DIGITS-1:0] An_out,
   output logic [6:0]            Seg_out,
   output logic                  DP_out
);

   localparam int                    PW     = $clog2(SCAN_DIV);
   localparam int                    IW     = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0]         PRE_TC = PW'(SCAN_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

   logic [PW-1:0] pre_cnt;
   logic [IW-1:0] idx;
   logic          frozen;
   logic          hold_rise;

   hold_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_hold_debouncer (
      .clk_sys  (Clk),
      .rst_b    (Rst),
      .hold_raw (Hold_in),
      .rise     (hold_rise)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         PC_shown <= '0;
         frozen   <= 1'b0;
      end else begin
         if (!frozen) PC_shown <= PC_in;
         if (hold_rise) frozen <= ~frozen;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pre_cnt <= '0;
         idx     <= '0;
      end else if (pre_cnt == PRE_TC) begin
         pre_cnt <= '0;
         idx     <= idx + 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Registered drive keeps the pad outputs glitch-free; the decimal point
   // on digit 0 marks a frozen display.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         An_out  <= '1;
         Seg_out <= SEG_BLANK;
         DP_out  <= 1'b1;
      end else begin
         An_out  <= ~(AN_ONE << idx);
         Seg_out <= hex7(PC_shown[{idx, 2'b00} +: 4]);
         DP_out  <= ~(frozen && (idx == '0));
      end
   end

endmodule

// File: tb/tb_pc_display_driver.sv
// Self-checking bench for pc_display_driver with SCAN_DIV=4, DEBOUNCE_CYCLES=3.
module tb_pc_display_driver;

   localparam int SCAN       = 4;
   localparam int DEB        = 3;
   localparam int FREEZE_LAT = 2 + DEB + 1;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] PC_in;
   logic        Hold_in;
   logic [31:0] PC_shown;
   logic [7:0]  An_out;
   logic [6:0]  Seg_out;
   logic        DP_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  an;
      logic [6:0]  seg;
   } scan_vec_t;

   typedef struct {
      int         due;
      logic [7:0] an;
      logic [6:0] seg;
   } sb_item_t;

   logic [6:0] hex_tbl [16];
   scan_vec_t  vecs [16];
   sb_item_t   sb_q [$];

   pc_display_driver #(
      .SCAN_DIV       (SCAN),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .PC_in   (PC_in),
      .Hold_in (Hold_in),
      .PC_shown(PC_shown),
      .An_out  (An_out),
      .Seg_out (Seg_out),
      .DP_out  (DP_out)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Digit whose output register is loaded at active edge c (c counted from reset release).
   function automatic int idx_at(input int c);
      return ((c - 1) / SCAN) % 8;
   endfunction

   task automatic tick();
      sb_item_t it;
      @(posedge Clk);
      #1;
      if (Rst) cyc++;
      while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         it = sb_q.pop_front();
         check("sb_an", An_out, it.an);
         check("sb_seg", Seg_out, it.seg);
      end
   endtask

   task automatic drive_pc(input logic [31:0] v);
      sb_item_t it;
      int i;
      PC_in  = v;
      i      = idx_at(cyc + 2);
      it.due = cyc + 2;
      it.an  = ~(8'b1 << i);
      it.seg = hex_tbl[v[4*i +: 4]];
      sb_q.push_back(it);
   endtask

   task automatic run_frame(input int base);
      int i;
      for (int k = 0; k < 32; k++) begin
         tick();
         i = idx_at(cyc);
         check("scan_an", An_out, vecs[base + i].an);
         check("scan_seg", Seg_out, vecs[base + i].seg);
      end
   endtask

   initial begin
      logic [7:0]  an_l  [8];
      logic [6:0]  seg_a [8];
      logic [6:0]  seg_b [8];
      logic [31:0] frozen_val;
      logic [31:0] v;
      int          guard;

      hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      an_l    = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      seg_a   = '{7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40, 7'h40};
      seg_b   = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      for (int i = 0; i < 8; i++) begin
         vecs[i]     = '{pc: 32'h00400004, an: an_l[i], seg: seg_a[i]};
         vecs[i + 8] = '{pc: 32'hFEDCBA98, an: an_l[i], seg: seg_b[i]};
      end

      // Reset state
      Rst     = 1'b0;
      Hold_in = 1'b0;
      PC_in   = 32'h0;
      repeat (3) tick();
      check("rst_an", An_out, 8'hFF);
      check("rst_seg", Seg_out, 7'h7F);
      check("rst_dp", DP_out, 1'b1);
      check("rst_pc", PC_shown, 32'h0);

      // First edges after release, then one full frame including the 7->0 wrap
      PC_in = vecs[0].pc;
      Rst   = 1'b1;
      tick();
      check("first_an", An_out, 8'hFE);
      check("first_seg", Seg_out, 7'h40);
      check("cap_lat", PC_shown, 32'h00400004);
      tick();
      check("first_digit_seg", Seg_out, 7'h19);
      run_frame(0);

      // Short bounce: no freeze
      Hold_in = 1'b1;
      tick();
      tick();
      Hold_in = 1'b0;
      for (int k = 0; k < 32; k++) begin
         tick();
         check("bounce_dp", DP_out, 1'b1);
      end
      PC_in = 32'h00400008;
      tick();
      check("bounce_track", PC_shown, 32'h00400008);

      // Long press: the PC sampled on the edge Frozen rises is the one held
      Hold_in = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         PC_in = 32'h00401000 + k;
         tick();
         check("freeze_pc", PC_shown, 32'h00401000 + ((k < FREEZE_LAT) ? k : FREEZE_LAT));
         if (k == 10) Hold_in = 1'b0;
      end
      frozen_val = 32'h00401000 + FREEZE_LAT;
      PC_in = 32'h0040000C;
      for (int k = 0; k < 32; k++) begin
         tick();
         check("frozen_pc", PC_shown, frozen_val);
         check("frozen_dp", DP_out, (idx_at(cyc) == 0) ? 1'b0 : 1'b1);
      end

      // Second press unfreezes; capture resumes one cycle after the toggle
      Hold_in = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check("unfreeze_pc", PC_shown, (k <= FREEZE_LAT) ? frozen_val : 32'h0040000C);
      end
      Hold_in = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("unfrozen_dp", DP_out, 1'b1);
      end

      // Random PC stream through the two-cycle display path
      for (int k = 0; k < 40; k++) begin
         v = $urandom;
         drive_pc(v);
         tick();
         check("track_pc", PC_shown, v);
      end
      tick();
      tick();
      check("sb_drain", sb_q.size(), 0);

      // Full digit table for FEDCBA98
      PC_in = vecs[8].pc;
      tick();
      tick();
      run_frame(8);

      // Freeze, reach digit 5, then assert reset between edges
      Hold_in = 1'b1;
      repeat (10) tick();
      Hold_in = 1'b0;
      repeat (8) tick();
      PC_in = 32'h11111111;
      tick();
      check("refreeze_pc", PC_shown, 32'hFEDCBA98);
      guard = 0;
      while (idx_at(cyc) != 5 && guard < 40) begin
         tick();
         guard++;
      end
      check("idx5_reached", (guard < 40) ? 1'b1 : 1'b0, 1'b1);
      check("idx5_an", An_out, 8'hDF);
      #2;
      Rst = 1'b0;
      #1;
      check("async_rst_an", An_out, 8'hFF);
      check("async_rst_seg", Seg_out, 7'h7F);
      check("async_rst_dp", DP_out, 1'b1);
      check("async_rst_pc", PC_shown, 32'h0);
      cyc = 0;
      sb_q.delete();
      repeat (2) tick();
      PC_in = 32'h12345678;
      Rst   = 1'b1;
      tick();
      check("restart_an", An_out, 8'hFE);
      check("restart_seg", Seg_out, 7'h40);
      check("restart_dp", DP_out, 1'b1);
      check("restart_pc", PC_shown, 32'h12345678);
      for (int k = 0; k < 32; k++) begin
         v = $urandom;
         drive_pc(v);
         tick();
         check("restart_track", PC_shown, v);
         check("restart_dp_run", DP_out, 1'b1);
      end
      tick();
      tick();
      check("sb_drain_end", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
